// File: rtl/network_driver.sv
// network_driver: host-side transmitter for the network block.
// Collects one frame of N_WORDS words from the host, pulses net_load, streams
// the frame on net_d one word per cycle, then waits for a rising edge on
// net_valid and hands net_q back to the host through a valid/ready handshake.
// A missing net_valid edge within TIMEOUT cycles returns res_err=1, res_q=0.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data       host word write strobe and data
//   wr_ready             driver accepts a host word this cycle
//   net_load             one-cycle start pulse to the network
//   net_d                stream word to the network
//   net_valid, net_q     network done level and 4-bit answer
//   res_valid, res_q     result available and captured answer
//   res_err              timeout flag (res_q is 0 when set)
//   res_ready            host consumes the result
//   busy                 high in every state except IDLE/FILL
module network_driver #(
    parameter int unsigned WORD_W  = 120,
    parameter int unsigned N_WORDS = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              net_load,
    output logic [WORD_W-1:0] net_d,
    input  logic              net_valid,
    input  logic [3:0]        net_q,
    output logic              res_valid,
    output logic [3:0]        res_q,
    output logic              res_err,
    input  logic              res_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(N_WORDS + 1);
    localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_d;
    logic [IDX_W-1:0]  s_idx, s_idx_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              nv_q;
    logic              nv_rise;
    logic              wr_we;
    logic [WORD_W-1:0] first_word;

    logic              wr_ready_d;
    logic              net_load_d;
    logic [WORD_W-1:0] net_d_d;
    logic              res_valid_d;
    logic [3:0]        res_q_d;
    logic              res_err_d;
    logic              busy_d;

    logic [WORD_W-1:0] frame_mem [N_WORDS];

    // A level already high on WAIT entry is not an edge: nv_q tracks every cycle.
    assign nv_rise = net_valid & ~nv_q;

    // Word 0 may be written on the same cycle START is decided (single-word frames).
    assign first_word = (wr_we && (wr_cnt == '0)) ? wr_data : frame_mem[0];

    // Frame buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_we) begin
            frame_mem[IDX_W'(wr_cnt)] <= wr_data;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_cnt    <= '0;
            s_idx     <= '0;
            to_cnt    <= '0;
            nv_q      <= 1'b0;
            wr_ready  <= 1'b1;
            net_load  <= 1'b0;
            net_d     <= '0;
            res_valid <= 1'b0;
            res_q     <= 4'h0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            wr_cnt    <= wr_cnt_d;
            s_idx     <= s_idx_d;
            to_cnt    <= to_cnt_d;
            nv_q      <= net_valid;
            wr_ready  <= wr_ready_d;
            net_load  <= net_load_d;
            net_d     <= net_d_d;
            res_valid <= res_valid_d;
            res_q     <= res_q_d;
            res_err   <= res_err_d;
            busy      <= busy_d;
        end
    end

    // Next state and next output values; outputs are decoded from the next state.
    always_comb begin
        state_d     = state;
        wr_cnt_d    = wr_cnt;
        s_idx_d     = s_idx;
        to_cnt_d    = '0;
        wr_we       = 1'b0;
        res_q_d     = res_q;
        res_err_d   = res_err;
        wr_ready_d  = 1'b0;
        net_load_d  = 1'b0;
        net_d_d     = '0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state)
            S_IDLE, S_FILL: begin
                if (wr_en && wr_ready) begin
                    wr_we    = 1'b1;
                    wr_cnt_d = wr_cnt + CNT_W'(1);
                    if (wr_cnt == CNT_W'(N_WORDS - 1)) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_START: begin
                state_d = S_STREAM;
                s_idx_d = '0;
            end
            S_STREAM: begin
                if (s_idx == IDX_W'(N_WORDS - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    s_idx_d = s_idx + IDX_W'(1);
                end
            end
            S_WAIT: begin
                // An edge on the timeout cycle still wins.
                if (nv_rise) begin
                    res_q_d   = net_q;
                    res_err_d = 1'b0;
                    state_d   = S_DONE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    res_q_d   = 4'h0;
                    res_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            S_DONE: begin
                if (res_valid && res_ready) begin
                    state_d  = S_IDLE;
                    wr_cnt_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                wr_cnt_d = '0;
            end
        endcase

        wr_ready_d  = (state_d == S_IDLE) || (state_d == S_FILL);
        busy_d      = !wr_ready_d;
        net_load_d  = (state_d == S_START);
        res_valid_d = (state_d == S_DONE);

        case (state_d)
            S_START:  net_d_d = first_word;
            S_STREAM: net_d_d = frame_mem[s_idx_d];
            default:  net_d_d = '0;
        endcase
    end

endmodule

// File: tb/tb_network_driver.sv
// tb_network_driver: directed bench for network_driver (WORD_W=120,
// N_WORDS=16, TIMEOUT=32). Inputs change and outputs are sampled on the
// falling edge; each falling edge stands for the cycle ending at the next rise.
module tb_network_driver;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [119:0] wr_data;
    logic         wr_ready;
    logic         net_load;
    logic [119:0] net_d;
    logic         net_valid;
    logic [3:0]   net_q;
    logic         res_valid;
    logic [3:0]   res_q;
    logic         res_err;
    logic         res_ready;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [119:0] words [16];

    network_driver #(
        .WORD_W (120),
        .N_WORDS(16),
        .TIMEOUT(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .net_load (net_load),
        .net_d    (net_d),
        .net_valid(net_valid),
        .net_q    (net_q),
        .res_valid(res_valid),
        .res_q    (res_q),
        .res_err  (res_err),
        .res_ready(res_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Load the expected frame and write it; returns at the START cycle.
    task automatic write_frame(input logic [119:0] base, input bit gapped);
        for (int i = 0; i < 16; i++) words[i] = base + 120'(i);
        chk("fill_wr_ready", 128'(wr_ready), 128'(1));
        chk("fill_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 16; i++) begin
            if (gapped && i > 0) begin
                wr_en   = 1'b0;
                wr_data = 120'hBAD;
                repeat ((i % 3) + 1) @(negedge clk);
            end
            wr_en   = 1'b1;
            wr_data = words[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Check START and all STREAM cycles; returns at WAIT cycle 0.
    task automatic check_stream(input bit garbage);
        chk("start_load", 128'(net_load), 128'(1));
        chk("start_d", 128'(net_d), 128'(words[0]));
        chk("start_wr_ready", 128'(wr_ready), 128'(0));
        chk("start_busy", 128'(busy), 128'(1));
        if (garbage) begin
            wr_en   = 1'b1;
            wr_data = ~words[0];
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("stream_d", 128'(net_d), 128'(words[k]));
            if (k == 0) chk("stream_load", 128'(net_load), 128'(0));
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("wait_d", 128'(net_d), 128'(0));
        chk("wait_res_valid", 128'(res_valid), 128'(0));
    endtask

    // Consume the result and confirm return to IDLE.
    task automatic finish_result();
        res_ready = 1'b1;
        @(negedge clk);
        chk("idle_res_valid", 128'(res_valid), 128'(0));
        chk("idle_wr_ready", 128'(wr_ready), 128'(1));
        chk("idle_busy", 128'(busy), 128'(0));
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        net_valid = 1'b0;
        net_q     = 4'h0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_load", 128'(net_load), 128'(0));
        chk("rst_d", 128'(net_d), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_err", 128'(res_err), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_wr_ready", 128'(wr_ready), 128'(1));
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a stream.
        write_frame(120'h50, 1'b0);
        chk("t1_load", 128'(net_load), 128'(1));
        repeat (3) @(negedge clk);
        chk("t1_stream_d", 128'(net_d), 128'(words[2]));
        rst = 1'b1;
        #1;
        chk("t1_rst_load", 128'(net_load), 128'(0));
        chk("t1_rst_d", 128'(net_d), 128'(0));
        chk("t1_rst_res_valid", 128'(res_valid), 128'(0));
        chk("t1_rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_wr_ready", 128'(wr_ready), 128'(1));
        chk("t1_idle_d", 128'(net_d), 128'(0));

        // Normal back-to-back frame 0x1..0x10.
        write_frame(120'h1, 1'b0);
        check_stream(1'b0);
        net_valid = 1'b1;
        net_q     = 4'hA;
        @(negedge clk);
        chk("t2_res_valid", 128'(res_valid), 128'(1));
        chk("t2_res_q", 128'(res_q), 128'(4'hA));
        chk("t2_res_err", 128'(res_err), 128'(0));
        chk("t2_busy", 128'(busy), 128'(1));
        net_valid = 1'b0;
        finish_result();

        // Gapped writes, with ignored writes during the stream.
        write_frame(120'h1234_5678_9ABC_DEF0_1111_2222_3333, 1'b1);
        check_stream(1'b1);
        @(negedge clk);
        net_valid = 1'b1;
        net_q     = 4'h6;
        @(negedge clk);
        chk("t3_res_valid", 128'(res_valid), 128'(1));
        chk("t3_res_q", 128'(res_q), 128'(4'h6));
        net_valid = 1'b0;
        finish_result();

        // Timeout: net_valid never rises.
        write_frame(120'hF00, 1'b0);
        check_stream(1'b0);
        repeat (31) @(negedge clk);
        chk("t4_before_timeout", 128'(res_valid), 128'(0));
        @(negedge clk);
        chk("t4_res_valid", 128'(res_valid), 128'(1));
        chk("t4_res_err", 128'(res_err), 128'(1));
        chk("t4_res_q", 128'(res_q), 128'(0));
        finish_result();

        // Stale net_valid high on WAIT entry.
        net_valid = 1'b1;
        net_q     = 4'h7;
        write_frame(120'hABC, 1'b0);
        check_stream(1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t5_no_capture", 128'(res_valid), 128'(0));
        end
        net_valid = 1'b0;
        @(negedge clk);
        chk("t5_low", 128'(res_valid), 128'(0));
        net_valid = 1'b1;
        net_q     = 4'h3;
        @(negedge clk);
        chk("t5_res_valid", 128'(res_valid), 128'(1));
        chk("t5_res_q", 128'(res_q), 128'(4'h3));
        chk("t5_res_err", 128'(res_err), 128'(0));
        net_valid = 1'b0;

        // Backpressure, then a second frame with res_ready held high.
        repeat (10) begin
            @(negedge clk);
            chk("t6_hold_valid", 128'(res_valid), 128'(1));
            chk("t6_hold_q", 128'(res_q), 128'(4'h3));
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t6_idle_res_valid", 128'(res_valid), 128'(0));
        chk("t6_idle_wr_ready", 128'(wr_ready), 128'(1));
        write_frame(120'h777, 1'b0);
        check_stream(1'b0);
        net_valid = 1'b1;
        net_q     = 4'h5;
        @(negedge clk);
        chk("t6_res_valid", 128'(res_valid), 128'(1));
        chk("t6_res_q", 128'(res_q), 128'(4'h5));
        net_valid = 1'b0;
        @(negedge clk);
        chk("t6_consumed", 128'(res_valid), 128'(0));
        chk("t6_wr_ready", 128'(wr_ready), 128'(1));
        res_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
